// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle ALUCtrl operations plus an iterative multiply/divide
// unit that owns the architectural HI/LO registers.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [4:0]       ALUCtrl,
  input  logic             Start,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       fsm_state
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  localparam logic [4:0] OP_MTHI = 5'd22;
  localparam logic [4:0] OP_MTLO = 5'd23;

  logic [1:0]       state;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done_q;

  // Working registers. Multiply: {acc_hi,acc_lo} is the partial product with the
  // multiplier shifting out of acc_lo, opnd is the multiplicand magnitude.
  // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend out and
  // the quotient in, opnd is the divisor magnitude.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_save;
  logic             op_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic [SHW-1:0]   sh;
  logic             slt;
  logic             sltu;
  logic [WIDTH-1:0] result;

  logic             is_muldiv;
  logic             op_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Start is a request qualified by the unit being idle: a mul/div/MTHI/MTLO is
  // taken on the rising edge where Start=1 and Busy=0; Start while Busy=1 is dropped.
  assign Busy      = (state != ST_IDLE);
  assign Done      = done_q;
  assign fsm_state = state;

  // Combinational ALU
  assign sh   = BusA[SHW-1:0];
  assign slt  = ($signed(BusA) < $signed(BusB));
  assign sltu = (BusA < BusB);

  always_comb begin
    result = '0;
    case (ALUCtrl)
      5'd0:       result = BusA & BusB;
      5'd1:       result = BusA | BusB;
      5'd2, 5'd8: result = BusA + BusB;
      5'd3:       result = BusB << sh;
      5'd4:       result = BusB >> sh;
      5'd6, 5'd9: result = BusA - BusB;
      5'd7:       result = {{(WIDTH-1){1'b0}}, slt};
      5'd10:      result = BusA ^ BusB;
      5'd11:      result = {{(WIDTH-1){1'b0}}, sltu};
      5'd12:      result = ~(BusA | BusB);
      5'd13:      result = WIDTH'($signed(BusB) >>> sh);
      5'd14:      result = BusB << (WIDTH / 2);
      5'd20:      result = hi;
      5'd21:      result = lo;
      default:    result = '0;
    endcase
  end

  assign BusW = result;
  assign Zero = (result == '0);

  // Operand conditioning at accept: codes 16..19, even codes are signed
  assign is_muldiv = (ALUCtrl[4:2] == 3'b100);
  assign op_signed = ~ALUCtrl[0];
  assign sign_a    = op_signed & BusA[WIDTH-1];
  assign sign_b    = op_signed & BusB[WIDTH-1];
  assign mag_a     = sign_a ? -BusA : BusA;
  assign mag_b     = sign_b ? -BusB : BusB;

  // One shift-add step
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

  // One restoring-division step; div_diff[WIDTH] set means the trial subtract borrowed
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  // Sign correction applied in FIX
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (op_div) begin
      if (div_zero) begin
        fix_hi = a_save;
        fix_lo = '1;
      end else begin
        fix_hi = neg_r ? -acc_hi : acc_hi;
        fix_lo = neg_q ? -acc_lo : acc_lo;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done_q   <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      a_save   <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (is_muldiv) begin
              acc_hi   <= '0;
              acc_lo   <= mag_a;
              opnd     <= mag_b;
              a_save   <= BusA;
              op_div   <= ALUCtrl[1];
              neg_q    <= sign_a ^ sign_b;
              neg_r    <= sign_a;
              div_zero <= (BusB == '0);
              cnt      <= '0;
              state    <= ALUCtrl[1] ? ST_DIV : ST_MUL;
            end else if (ALUCtrl == OP_MTHI) begin
              hi <= BusA;
            end else if (ALUCtrl == OP_MTLO) begin
              lo <= BusA;
            end
          end
        end
        ST_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) state <= ST_FIX;
        end
        ST_DIV: begin
          if (!div_diff[WIDTH]) begin
            acc_hi <= div_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          hi     <= fix_hi;
          lo     <= fix_lo;
          done_q <= 1'b1;
          cnt    <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: 32-bit instance checked every cycle against an arithmetic
// model, plus a 16-bit instance driven with directed vectors.
module tb_alu_muldiv;

  // Clock / reset
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic [31:0] BusA, BusB, BusW;
  logic [4:0]  ALUCtrl;
  logic        Start, Zero, Busy, Done;
  logic [1:0]  fsm_state;

  logic        rst16;
  logic [15:0] a16, b16, w16;
  logic [4:0]  ctrl16;
  logic        start16, zero16, busy16, done16;
  logic [1:0]  st16;

  alu_muldiv #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl),
    .Start(Start), .BusW(BusW), .Zero(Zero), .Busy(Busy), .Done(Done),
    .fsm_state(fsm_state)
  );

  alu_muldiv #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(rst16), .BusA(a16), .BusB(b16), .ALUCtrl(ctrl16),
    .Start(start16), .BusW(w16), .Zero(zero16), .Busy(busy16), .Done(done16),
    .fsm_state(st16)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural model of the 32-bit unit
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_busy = 0;
  bit          m_done = 1'b0;

  function automatic logic [31:0] comb_model(input logic [4:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    logic [31:0] r;
    case (c)
      5'd0:       r = a & b;
      5'd1:       r = a | b;
      5'd2, 5'd8: r = a + b;
      5'd3:       r = b << a[4:0];
      5'd4:       r = b >> a[4:0];
      5'd6, 5'd9: r = a - b;
      5'd7:       r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      5'd10:      r = a ^ b;
      5'd11:      r = (a < b) ? 32'd1 : 32'd0;
      5'd12:      r = ~(a | b);
      5'd13:      r = 32'($signed(b) >>> a[4:0]);
      5'd14:      r = {b[15:0], 16'h0000};
      5'd20:      r = hi;
      5'd21:      r = lo;
      default:    r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic muldiv_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint      sp;
    int          sa, sb;
    sa = int'(a);
    sb = int'(b);
    hi = '0;
    lo = '0;
    case (c)
      5'd16: begin
        sp = longint'(sa) * longint'(sb);
        p  = 64'(sp);
        hi = p[63:32];
        lo = p[31:0];
      end
      5'd17: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      5'd18: begin
        if (b == 0) begin
          hi = a; lo = '1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 0; lo = a;
        end else begin
          hi = 32'(sa % sb); lo = 32'(sa / sb);
        end
      end
      default: begin
        if (b == 0) begin
          hi = a; lo = '1;
        end else begin
          hi = a % b; lo = a / b;
        end
      end
    endcase
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      m_done = (m_busy == 0);
      if (m_busy == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else begin
      m_done = 1'b0;
      if (Start) begin
        if (ALUCtrl >= 5'd16 && ALUCtrl <= 5'd19) begin
          muldiv_model(ALUCtrl, BusA, BusB, p_hi, p_lo);
          m_busy = 33;
        end else if (ALUCtrl == 5'd22) m_hi = BusA;
        else if (ALUCtrl == 5'd23) m_lo = BusA;
      end
    end
  end

  // Scoreboard compare on every falling edge
  always @(negedge Clk) begin
    logic [31:0] e;
    if (chk_en) begin
      e = comb_model(ALUCtrl, BusA, BusB, m_hi, m_lo);
      check("busw", BusW, e);
      check("zero", {31'd0, Zero}, {31'd0, (e == 32'd0)});
      check("busy", {31'd0, Busy}, {31'd0, (m_busy > 0)});
      check("done", {31'd0, Done}, {31'd0, m_done});
    end
  end

  // Driver tasks
  task automatic drive(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic s);
    @(posedge Clk); #1;
    ALUCtrl = c; BusA = a; BusB = b; Start = s;
  endtask

  task automatic drive_chk(input string name, input logic [4:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    drive(c, a, b, 1'b0);
    @(negedge Clk);
    check(name, BusW, exp);
  endtask

  task automatic wait_done(output int bc, output bit got);
    bc = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (Done) begin
        got = 1'b1;
        break;
      end
      if (Busy) bc++;
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int bc;
    bit got;
    drive(c, a, b, 1'b1);
    drive(5'd20, 32'd0, 32'd0, 1'b0);
    wait_done(bc, got);
    check($sformatf("%s_done", name), {31'd0, got}, 32'd1);
    check($sformatf("%s_busy_cycles", name), 32'(bc), 32'd33);
    check($sformatf("%s_hi", name), BusW, exp_hi);
    drive_chk($sformatf("%s_lo", name), 5'd21, 32'd0, 32'd0, exp_lo);
  endtask

  initial begin
    int  bc;
    bit  got;
    int  dcnt;

    Reset = 1'b1; ALUCtrl = 5'd20; BusA = '0; BusB = '0; Start = 1'b0;
    rst16 = 1'b1; ctrl16 = 5'd0; a16 = '0; b16 = '0; start16 = 1'b0;
    @(posedge Clk);
    chk_en = 1'b1;
    @(negedge Clk);
    check("reset_mfhi", BusW, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    rst16 = 1'b0;

    // Combinational regression
    drive_chk("and",   5'd0,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    drive_chk("or",    5'd1,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF);
    drive_chk("add",   5'd2,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    drive_chk("sll",   5'd3,  32'd4,         32'h8000_0001, 32'h0000_0010);
    drive_chk("srl",   5'd4,  32'd6,         32'hFFFF_1234, 32'h03FF_FC48);
    drive_chk("rsv5",  5'd5,  32'd1,         32'd1,         32'd0);
    drive_chk("sub",   5'd6,  32'd0,         32'd1,         32'hFFFF_FFFF);
    drive_chk("slt_a", 5'd7,  32'hFFFF_FFFF, 32'd1,         32'd1);
    drive_chk("slt_b", 5'd7,  32'd1,         32'hFFFF_FFFF, 32'd0);
    drive_chk("addu",  5'd8,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000);
    drive_chk("subu",  5'd9,  32'd1,         32'd1,         32'd0);
    check("subu_zero", {31'd0, Zero}, 32'd1);
    drive_chk("xor",   5'd10, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
    drive_chk("sltu",  5'd11, 32'd0,         32'hFFFF_FFFF, 32'd1);
    drive_chk("nor",   5'd12, 32'd0,         32'd0,         32'hFFFF_FFFF);
    drive_chk("sra",   5'd13, 32'd6,         32'hFFFF_1234, 32'hFFFF_FC48);
    drive_chk("sra_sh_mask", 5'd13, 32'h0000_0026, 32'hFFFF_1234, 32'hFFFF_FC48);
    drive_chk("lui",   5'd14, 32'd0,         32'h1234_5678, 32'h5678_0000);
    drive_chk("rsv15", 5'd15, 32'hFFFF,      32'hFFFF,      32'd0);
    drive_chk("rsv24", 5'd24, 32'hFFFF,      32'hFFFF,      32'd0);
    drive_chk("rsv31", 5'd31, 32'hFFFF,      32'hFFFF,      32'd0);
    drive_chk("mflo_reset", 5'd21, 32'd0,    32'd0,         32'd0);

    // MULTU with old HI observed while busy
    drive(5'd22, 32'h1111_2222, 32'd0, 1'b1);
    drive(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drive(5'd20, 32'd0, 32'd0, 1'b0);
    @(negedge Clk);
    check("mfhi_while_busy", BusW, 32'h1111_2222);
    check("multu_busy_first", {31'd0, Busy}, 32'd1);
    wait_done(bc, got);
    check("multu_done", {31'd0, got}, 32'd1);
    check("multu_busy_cycles", 32'(bc + 1), 32'd33);
    check("multu_hi", BusW, 32'hFFFF_FFFE);
    drive_chk("multu_lo", 5'd21, 32'd0, 32'd0, 32'h0000_0001);

    // Signed and corner-case mul/div
    run_op("mult_m3x5",   5'd16, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_7xm1",   5'd16, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run_op("mult_minmin", 5'd16, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_m7d2",    5'd18, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7dm2",    5'd18, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf",     5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_7d0",    5'd19, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div_m7d0",    5'd18, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("divu_big",    5'd19, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF);

    // MTLO while busy is dropped
    drive(5'd17, 32'd3, 32'd4, 1'b1);
    drive(5'd23, 32'h55, 32'd0, 1'b1);
    drive(5'd21, 32'd0, 32'd0, 1'b0);
    wait_done(bc, got);
    check("mtlo_busy_done", {31'd0, got}, 32'd1);
    check("mtlo_busy_ignored", BusW, 32'h0000_000C);

    // Back-to-back issue in the Done cycle
    drive(5'd16, 32'd6, 32'd7, 1'b1);
    drive(5'd20, 32'd0, 32'd0, 1'b0);
    wait_done(bc, got);
    check("b2b_first_done", {31'd0, got}, 32'd1);
    check("b2b_first_hi", BusW, 32'd0);
    #1;
    ALUCtrl = 5'd16; BusA = 32'hFFFF_FFFE; BusB = 32'hFFFF_FFF7; Start = 1'b1;
    @(posedge Clk); #1;
    ALUCtrl = 5'd21; Start = 1'b0;
    @(negedge Clk);
    check("b2b_accepted_busy", {31'd0, Busy}, 32'd1);
    check("b2b_old_lo", BusW, 32'h0000_002A);
    wait_done(bc, got);
    check("b2b_second_done", {31'd0, got}, 32'd1);
    check("b2b_second_lo", BusW, 32'h0000_0012);

    // MTHI visible on the next cycle
    drive(5'd22, 32'hABCD_0000, 32'd0, 1'b1);
    drive_chk("mthi_read", 5'd20, 32'd0, 32'd0, 32'hABCD_0000);

    // Reset in the middle of a divide
    drive(5'd18, 32'd100, 32'd7, 1'b1);
    drive(5'd20, 32'd0, 32'd0, 1'b0);
    repeat (10) @(negedge Clk);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_mid_busy", {31'd0, Busy}, 32'd0);
    check("rst_mid_hi", BusW, 32'd0);
    drive_chk("rst_mid_lo", 5'd21, 32'd0, 32'd0, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done) dcnt++;
    end
    check("rst_mid_no_done", 32'(dcnt), 32'd0);
    run_op("divu_after_rst", 5'd19, 32'd100, 32'd7, 32'd2, 32'd14);

    // 16-bit instance
    @(posedge Clk); #1;
    ctrl16 = 5'd14; a16 = 16'h0; b16 = 16'h1234;
    @(negedge Clk);
    check("w16_lui", {16'd0, w16}, 32'h0000_3400);
    @(posedge Clk); #1;
    ctrl16 = 5'd13; a16 = 16'd15; b16 = 16'h8000;
    @(negedge Clk);
    check("w16_sra", {16'd0, w16}, 32'h0000_FFFF);
    @(posedge Clk); #1;
    ctrl16 = 5'd4;
    @(negedge Clk);
    check("w16_srl", {16'd0, w16}, 32'h0000_0001);

    @(posedge Clk); #1;
    ctrl16 = 5'd17; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    @(posedge Clk); #1;
    ctrl16 = 5'd20; start16 = 1'b0;
    bc = 0; got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (done16) begin
        got = 1'b1;
        break;
      end
      if (busy16) bc++;
    end
    check("w16_multu_done", {31'd0, got}, 32'd1);
    check("w16_multu_busy_cycles", 32'(bc), 32'd17);
    check("w16_multu_hi", {16'd0, w16}, 32'h0000_FFFE);
    @(posedge Clk); #1;
    ctrl16 = 5'd21;
    @(negedge Clk);
    check("w16_multu_lo", {16'd0, w16}, 32'h0000_0001);

    @(posedge Clk); #1;
    ctrl16 = 5'd18; a16 = 16'hFFF9; b16 = 16'd2; start16 = 1'b1;
    @(posedge Clk); #1;
    ctrl16 = 5'd21; start16 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (done16) begin
        got = 1'b1;
        break;
      end
    end
    check("w16_div_done", {31'd0, got}, 32'd1);
    check("w16_div_lo", {16'd0, w16}, 32'h0000_FFFD);
    @(posedge Clk); #1;
    ctrl16 = 5'd20;
    @(negedge Clk);
    check("w16_div_hi", {16'd0, w16}, 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
